ifu_fetch_bp: RTL and testbench

- Instruction fetch front end. Generates the PC, fetches one instruction at a time from the instruction memory port, and predicts next-PC with a small direct-mapped BTB.
- Delivers {inst, pc, pred_res} to the decode stage over a valid/ready handshake.
- Consumes decode-stage branch commits (br_commit, br_error, br_pc, br_npc, br_type) to train the BTB and redirect fetch, and returns inst_kill to decode.

---
 rtl/ifu_fetch_bp_pkg.sv | 34 +++
 rtl/ifu_btb.sv | 59 +++++
 rtl/ifu_fetch_bp.sv | 156 +++++++++++++++
 tb/tb_ifu_fetch_bp.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_bp_pkg.sv
// Shared types for the instruction fetch front end.
//   br_type_e     : resolved branch kinds reported by decode
//   fetch_state_e : fetch sequencer states
//   fetch_pkt_t   : packet handed to decode {inst, pc, pred_res}
//   word_align()  : clears the byte offset of an address
package ifu_fetch_bp_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

    typedef enum logic [1:0] {
        BR_TYPE_JAL  = 2'd0,
        BR_TYPE_JALR = 2'd1,
        BR_TYPE_B    = 2'd2,
        BR_TYPE_NONE = 2'd3
    } br_type_e;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StDrop,
        StHold
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic        pred_res;
        logic [31:0] pc;
    } fetch_pkt_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/ifu_btb.sv
// Direct-mapped branch target buffer.
//   clock, reset      : clock and synchronous active-low reset (clears valid bits only)
//   i_lookup_word     : fetch PC without its byte offset (pc[31:2]), combinational lookup
//   o_hit, o_target   : lookup result; target is meaningful only when o_hit is set
//   i_we, i_waddr_word: write strobe and PC (pc[31:2]) of the entry to train
//   i_wtarget         : target stored with the entry
module ifu_btb
    import ifu_fetch_bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [29:0] i_lookup_word,
    output logic        o_hit,
    output logic [31:0] o_target,
    input  logic        i_we,
    input  logic [29:0] i_waddr_word,
    input  logic [31:0] i_wtarget
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];

    logic [IDX-1:0]     w_ridx;
    logic [IDX-1:0]     w_widx;
    logic [TAG_W-1:0]   w_rtag;
    logic [TAG_W-1:0]   w_wtag;

    assign w_ridx = i_lookup_word[IDX-1:0];
    assign w_rtag = i_lookup_word[29:IDX];
    assign w_widx = i_waddr_word[IDX-1:0];
    assign w_wtag = i_waddr_word[29:IDX];

    // Reads see the pre-write contents when a write hits the same index this cycle.
    assign o_hit    = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);
    assign o_target = r_target[w_ridx];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[w_widx] <= 1'b1;
        end
    end

    // Payload needs no reset: a cleared valid bit masks stale contents.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_tag[w_widx]    <= w_wtag;
            r_target[w_widx] <= i_wtarget;
        end
    end

endmodule

// File: rtl/ifu_fetch_bp.sv
// Instruction fetch front end with BTB next-PC prediction.
//   clock, reset      : clock and synchronous active-low reset
//   imem_req_*        : one-at-a-time fetch request (valid/ready, word-aligned address)
//   imem_rsp_*        : single-cycle response strobe and instruction word
//   master_valid/ready: fetch packet handshake towards decode
//   inst, pc, pred_res: fetch packet; pred_res=1 means BTB hit, predicted taken
//   inst_kill         : one-cycle registered flush pulse following a redirect
//   br_*              : branch resolution from decode; JAL commits train the BTB,
//                       br_error redirects fetch to br_npc
module ifu_fetch_bp
    import ifu_fetch_bp_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned BTB_ENTRIES = 8
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        master_valid,
    input  logic        master_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        pred_res,
    output logic        inst_kill,
    input  logic        br_commit,
    input  logic        br_error,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_npc,
    input  logic [1:0]  br_type
);

    fetch_state_e r_state, w_state_nxt;
    logic         r_run;
    logic [31:0]  r_fetch_pc, w_fetch_pc_nxt;
    logic [31:0]  r_req_pc, w_req_pc_nxt;
    logic         r_req_pred, w_req_pred_nxt;
    fetch_pkt_t   r_pkt, w_pkt_nxt;
    logic         r_mvalid, w_mvalid_nxt;
    logic         r_kill;

    logic         w_hit;
    logic [31:0]  w_target;
    logic         w_accept;
    logic         w_btb_we;

    ifu_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clock         (clock),
        .reset         (reset),
        .i_lookup_word (r_fetch_pc[31:2]),
        .o_hit         (w_hit),
        .o_target      (w_target),
        .i_we          (w_btb_we),
        .i_waddr_word  (br_pc[31:2]),
        .i_wtarget     (br_npc)
    );

    // Training runs regardless of fetch state or redirects.
    assign w_btb_we = br_commit && (br_type_e'(br_type) == BR_TYPE_JAL);

    // r_run holds off the first request until the cycle after reset releases.
    assign imem_req_valid = (r_state == StReq) && r_run;
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign master_valid = r_mvalid;
    assign inst         = r_pkt.inst;
    assign pc           = r_pkt.pc;
    assign pred_res     = r_pkt.pred_res;
    assign inst_kill    = r_kill;

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_pc_nxt   = r_req_pc;
        w_req_pred_nxt = r_req_pred;
        w_pkt_nxt      = r_pkt;
        w_mvalid_nxt   = r_mvalid;

        unique case (r_state)
            StReq: begin
                if (w_accept) begin
                    w_req_pc_nxt   = r_fetch_pc;
                    w_req_pred_nxt = w_hit;
                    w_fetch_pc_nxt = w_hit ? word_align(w_target) : r_fetch_pc + 32'd4;
                    w_state_nxt    = StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    w_pkt_nxt.inst     = imem_rsp_data;
                    w_pkt_nxt.pc       = r_req_pc;
                    w_pkt_nxt.pred_res = r_req_pred;
                    w_mvalid_nxt       = 1'b1;
                    w_state_nxt        = StHold;
                end
            end
            StHold: begin
                if (r_mvalid && master_ready) begin
                    w_mvalid_nxt = 1'b0;
                    w_state_nxt  = StReq;
                end
            end
            StDrop: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = StReq;
                end
            end
            default: begin
                w_state_nxt = StReq;
            end
        endcase

        // Redirect overrides everything above, including a same-cycle transfer or response.
        if (br_error) begin
            w_fetch_pc_nxt = word_align(br_npc);
            w_mvalid_nxt   = 1'b0;
            w_pkt_nxt      = r_pkt;
            unique case (r_state)
                StReq:   w_state_nxt = w_accept ? StDrop : StReq;
                StWait:  w_state_nxt = imem_rsp_valid ? StReq : StDrop;
                StHold:  w_state_nxt = StReq;
                StDrop:  w_state_nxt = imem_rsp_valid ? StReq : StDrop;
                default: w_state_nxt = StReq;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= StReq;
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_req_pred <= 1'b0;
            r_pkt      <= '0;
            r_mvalid   <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_run      <= 1'b1;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_pc   <= w_req_pc_nxt;
            r_req_pred <= w_req_pred_nxt;
            r_pkt      <= w_pkt_nxt;
            r_mvalid   <= w_mvalid_nxt;
            r_kill     <= br_error;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_bp.sv
module tb_ifu_fetch_bp;
    import ifu_fetch_bp_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        master_valid;
    logic        master_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_res;
    logic        inst_kill;
    logic        br_commit = 1'b0;
    logic        br_error = 1'b0;
    logic [31:0] br_pc = '0;
    logic [31:0] br_npc = '0;
    logic [1:0]  br_type = 2'd3;

    ifu_fetch_bp dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .master_valid   (master_valid),
        .master_ready   (master_ready),
        .inst           (inst),
        .pc             (pc),
        .pred_res       (pred_res),
        .inst_kill      (inst_kill),
        .br_commit      (br_commit),
        .br_error       (br_error),
        .br_pc          (br_pc),
        .br_npc         (br_npc),
        .br_type        (br_type)
    );

    always #5 clock = ~clock;

    int vecs = 0;
    int miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:16] ^ a[15:0], a[15:0] ^ 16'hC3A5};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        rst_n, rsp, mrdy, commit, err;
        logic [31:0] bpc, bnpc;
        logic [1:0]  btype;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_mv;
        logic [31:0] e_pc;
        logic        e_pred, e_kill;
    } vec_t;

    function automatic vec_t mk(input logic rsp, mrdy, commit, err,
                                input logic [31:0] bpc, bnpc, input logic [1:0] bt,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_mv, input logic [31:0] e_pc,
                                input logic e_pred, e_kill);
        vec_t v;
        v.rst_n = 1'b1; v.rsp = rsp; v.mrdy = mrdy; v.commit = commit; v.err = err;
        v.bpc = bpc; v.bnpc = bnpc; v.btype = bt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_mv = e_mv; v.e_pc = e_pc;
        v.e_pred = e_pred; v.e_kill = e_kill;
        return v;
    endfunction

    task automatic redirect(input string tag, input logic [31:0] npc);
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        br_commit = 1'b0; br_error = 1'b1; br_npc = npc;
        tick();
        br_error = 1'b0;
        chk({tag, "_kill"}, inst_kill, 1);
    endtask

    task automatic train(input logic [31:0] bpc, input logic [31:0] npc);
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        br_commit = 1'b1; br_error = 1'b0; br_type = BR_TYPE_JAL; br_pc = bpc; br_npc = npc;
        tick();
        br_commit = 1'b0; br_type = BR_TYPE_NONE;
    endtask

    // One full request/response/transfer with 1-cycle memory latency.
    task automatic fetch_one(input string tag, input logic [31:0] ea, input logic ep);
        int n = 0;
        logic [31:0] a;
        imem_req_ready = 1'b1; master_ready = 1'b1; imem_rsp_valid = 1'b0;
        br_commit = 1'b0; br_error = 1'b0;
        while (imem_req_valid !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, imem_req_valid, 1);
        chk({tag, "_addr"}, imem_req_addr, ea);
        a = imem_req_addr;
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(a);
        tick();
        imem_rsp_valid = 1'b0;
        chk({tag, "_mv"}, master_valid, 1);
        chk({tag, "_pc"}, pc, ea);
        chk({tag, "_inst"}, inst, mem_word(ea));
        chk({tag, "_pred"}, pred_res, ep);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        logic [31:0] last_addr;
        logic [1:0]  N, J, B;
        N = BR_TYPE_NONE; J = BR_TYPE_JAL; B = BR_TYPE_B;
        last_addr = '0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_mvalid", master_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", pc, 0);
        chk("rst_pred", pred_res, 0);
        chk("rst_kill", inst_kill, 0);

        // ---------------- table-driven directed run ----------------
        // Row i: expected outputs seen now, inputs driven for the coming edge.
        tbl.push_back(mk(0,1,0,0,0,0,N, 0,0,           0,0,           0,0)); // release reset
        tbl.push_back(mk(0,1,0,0,0,0,N, 1,BASE,        0,0,           0,0));
        tbl.push_back(mk(1,1,0,0,0,0,N, 0,0,           0,0,           0,0));
        tbl.push_back(mk(0,1,0,0,0,0,N, 0,0,           1,BASE,        0,0));
        tbl.push_back(mk(0,1,0,0,0,0,N, 1,BASE+4,      0,0,           0,0));
        tbl.push_back(mk(1,1,0,0,0,0,N, 0,0,           0,0,           0,0));
        tbl.push_back(mk(0,1,0,0,0,0,N, 0,0,           1,BASE+4,      0,0));
        tbl.push_back(mk(0,1,0,0,0,0,N, 1,BASE+8,      0,0,           0,0));
        tbl.push_back(mk(1,1,0,0,0,0,N, 0,0,           0,0,           0,0));
        for (int i = 0; i < 5; i++)                                           // decode stalls
            tbl.push_back(mk(0,0,0,0,0,0,N, 0,0,       1,BASE+8,      0,0));
        tbl.push_back(mk(0,1,1,1,BASE+8,BASE+32'h100,J, 0,0, 1,BASE+8, 0,0)); // JAL mispredict
        tbl.push_back(mk(0,1,0,0,0,0,N, 1,BASE+32'h100,0,0,           0,1));
        tbl.push_back(mk(1,1,0,0,0,0,N, 0,0,           0,0,           0,0));
        tbl.push_back(mk(0,1,1,1,BASE+32'h100,BASE+8,B, 0,0, 1,BASE+32'h100,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,N, 1,BASE+8,      0,0,           0,1));
        tbl.push_back(mk(1,1,0,0,0,0,N, 0,0,           0,0,           0,0));
        tbl.push_back(mk(0,1,0,0,0,0,N, 0,0,           1,BASE+8,      1,0)); // BTB hit
        tbl.push_back(mk(0,1,0,0,0,0,N, 1,BASE+32'h100,0,0,           0,0));
        tbl.push_back(mk(0,1,0,1,0,BASE+32'h200,N, 0,0, 0,0,          0,0)); // redirect in WAIT
        tbl.push_back(mk(0,1,0,0,0,0,N, 0,0,           0,0,           0,1));
        tbl.push_back(mk(1,1,0,0,0,0,N, 0,0,           0,0,           0,0)); // stale response
        tbl.push_back(mk(0,1,0,0,0,0,N, 1,BASE+32'h200,0,0,           0,0));
        tbl.push_back(mk(1,1,0,0,0,0,N, 0,0,           0,0,           0,0));
        tbl.push_back(mk(0,1,0,0,0,0,N, 0,0,           1,BASE+32'h200,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            chk($sformatf("t%0d_req_valid", i), imem_req_valid, v.e_req);
            if (v.e_req) chk($sformatf("t%0d_req_addr", i), imem_req_addr, v.e_addr);
            chk($sformatf("t%0d_mvalid", i), master_valid, v.e_mv);
            if (v.e_mv) begin
                chk($sformatf("t%0d_pc", i), pc, v.e_pc);
                chk($sformatf("t%0d_inst", i), inst, mem_word(v.e_pc));
                chk($sformatf("t%0d_pred", i), pred_res, v.e_pred);
            end
            chk($sformatf("t%0d_kill", i), inst_kill, v.e_kill);
            reset = v.rst_n;
            imem_req_ready = 1'b1;
            imem_rsp_valid = v.rsp;
            imem_rsp_data = v.rsp ? mem_word(last_addr) : 32'hDEAD_0000;
            if (imem_req_valid === 1'b1) last_addr = imem_req_addr;
            master_ready = v.mrdy;
            br_commit = v.commit; br_error = v.err;
            br_pc = v.bpc; br_npc = v.bnpc; br_type = v.btype;
            tick();
        end
        br_commit = 1'b0; br_error = 1'b0; imem_rsp_valid = 1'b0;

        // ---------------- BTB aliasing: same index, different tag ----------------
        train(BASE + 32'h28, BASE + 32'h400);
        redirect("al1", BASE + 32'h8);
        fetch_one("al_08", BASE + 32'h8, 1'b0);
        fetch_one("al_0c", BASE + 32'hC, 1'b0);
        redirect("al2", BASE + 32'h28);
        fetch_one("al_28", BASE + 32'h28, 1'b1);
        fetch_one("al_400", BASE + 32'h400, 1'b0);

        // ---------------- reset while waiting on memory ----------------
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; reset = 1'b0;
        tick();
        chk("rw_req_in_reset", imem_req_valid, 0);
        chk("rw_mv_in_reset", master_valid, 0);
        reset = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        chk("rw_mv_late_rsp", master_valid, 0);
        chk("rw_req", imem_req_valid, 1);
        chk("rw_addr", imem_req_addr, BASE);
        tick();
        chk("rw_mv_after", master_valid, 0);
        fetch_one("rw_00", BASE, 1'b0);
        fetch_one("rw_04", BASE + 32'h4, 1'b0);
        fetch_one("rw_08", BASE + 32'h8, 1'b0);
        fetch_one("rw_0c", BASE + 32'hC, 1'b0);
        redirect("rw3", BASE + 32'h28);
        fetch_one("rw_28", BASE + 32'h28, 1'b0);
        fetch_one("rw_2c", BASE + 32'h2C, 1'b0);

        // ---------------- randomized run against a transaction model ----------------
        begin
            logic [31:0] exp_addr, held_pc, mem_addr;
            bit          held, held_pred, mem_busy, mem_live, mem_pred, kill_exp;
            bit          exp_req, acc, rsp, err, hit;
            int          mem_wait, idx, deliveries;
            bit          bv   [8];
            logic [31:0] bpcm [8];
            logic [31:0] btgt [8];

            reset = 1'b0; imem_req_ready = 1'b0; master_ready = 1'b0;
            tick();
            reset = 1'b1;
            tick();
            for (int i = 0; i < 8; i++) bv[i] = 1'b0;
            exp_addr = BASE; held = 0; held_pred = 0; held_pc = '0;
            mem_busy = 0; mem_live = 0; mem_pred = 0; mem_addr = '0; mem_wait = 0;
            kill_exp = 0; deliveries = 0;

            for (int cyc = 0; cyc < 3000; cyc++) begin
                exp_req = !held && !mem_busy;
                chk("r_req_valid", imem_req_valid, exp_req);
                if (exp_req) chk("r_req_addr", imem_req_addr, exp_addr);
                chk("r_mvalid", master_valid, held);
                if (held) begin
                    chk("r_pc", pc, held_pc);
                    chk("r_inst", inst, mem_word(held_pc));
                    chk("r_pred", pred_res, held_pred);
                end
                chk("r_kill", inst_kill, kill_exp);

                imem_req_ready = ($urandom % 4) != 0;
                master_ready   = ($urandom % 3) != 0;
                rsp            = mem_busy && (mem_wait == 0);
                imem_rsp_valid = rsp;
                imem_rsp_data  = rsp ? mem_word(mem_addr) : $urandom;
                br_commit      = ($urandom % 6) == 0;
                br_type        = 2'($urandom % 4);
                br_pc          = BASE + 32'(($urandom % 32) * 4);
                br_npc         = BASE + 32'(($urandom % 32) * 4) + 32'($urandom % 4);
                err            = ($urandom % 10) == 0;
                br_error       = err;

                acc = exp_req && imem_req_ready;
                if (held && master_ready && !err) begin
                    held = 0;
                    deliveries++;
                end
                if (rsp) begin
                    mem_busy = 0;
                    if (mem_live && !err) begin
                        held = 1; held_pc = mem_addr; held_pred = mem_pred;
                    end
                end else if (mem_busy) begin
                    mem_wait--;
                end
                if (acc) begin
                    idx = int'((exp_addr >> 2) % 8);
                    hit = bv[idx] && (bpcm[idx][31:2] == exp_addr[31:2]);
                    mem_busy = 1; mem_live = 1; mem_addr = exp_addr; mem_pred = hit;
                    mem_wait = int'($urandom % 3);
                    exp_addr = hit ? word_align(btgt[idx]) : exp_addr + 32'd4;
                end
                if (err) begin
                    held = 0; mem_live = 0; exp_addr = word_align(br_npc);
                end
                kill_exp = err;
                if (br_commit && br_type == BR_TYPE_JAL) begin
                    idx = int'((br_pc >> 2) % 8);
                    bv[idx] = 1'b1; bpcm[idx] = br_pc; btgt[idx] = br_npc;
                end
                tick();
            end
            br_commit = 1'b0; br_error = 1'b0; imem_rsp_valid = 1'b0;
            chk("r_progress", 32'(deliveries >= 100), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
